// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, fetch FSM encoding, reset PC.
package cpu_pkg;

  localparam int INSTR_W  = 16;
  localparam int RESET_PC = 0;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_FULL  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack, 1-entry prefetch buffer, IR.
// Feeds the control unit, which consumes via ir_en / increment pulses.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = INSTR_W,
  parameter int RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              increment,
  input  logic              ir_en,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_stall
);

  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] fetch_pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] addr_q;
  logic              req_q;
  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] ir_q;
  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;
  logic              pend_q;
  logic              pend_inc_q;
  logic              ld_inc;
  logic              ack_ok;

  assign pc_inc = fetch_pc_q + ADDR_W'(1);
  assign ack_ok = req_q && imem_ack;
  assign ld_inc = pend_q ? pend_inc_q : increment;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (pc_load) begin
      fetch_pc_d = pc_load_addr;
    end else begin
      unique case (state_q)
        S_FULL: begin
          if (increment) fetch_pc_d = pc_inc;
        end
        S_REQ: begin
          if (ack_ok) begin
            if (ld_inc) fetch_pc_d = pc_inc;
          end else if (!pend_q && !ir_en && increment) begin
            fetch_pc_d = pc_inc;
          end
        end
        S_DRAIN: begin
          if (!pend_q && !ir_en && increment)
            fetch_pc_d = pc_inc;
        end
        default: fetch_pc_d = fetch_pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      fetch_pc_q <= PC0;
      addr_q     <= PC0;
      req_q      <= 1'b1;
      buf_q      <= '0;
      ir_q       <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_inc_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      unique case (state_q)
        S_REQ: begin
          if (!req_q) begin
            // idle cycle after an ack: launch the next fetch
            req_q  <= 1'b1;
            addr_q <= fetch_pc_d;
            if (pc_load) begin
              pend_q <= 1'b0;
            end else if (ir_en) begin
              pend_q     <= 1'b1;
              pend_inc_q <= increment;
            end
          end else if (imem_ack) begin
            req_q <= 1'b0;
            if (pc_load) begin
              pend_q <= 1'b0;
            end else if (pend_q || ir_en) begin
              ir_q    <= imem_rdata;
              pc_q    <= fetch_pc_q;
              valid_q <= 1'b1;
              pend_q  <= 1'b0;
              if (!ld_inc) begin
                buf_q   <= imem_rdata;
                state_q <= S_FULL;
              end
            end else if (!increment) begin
              buf_q   <= imem_rdata;
              state_q <= S_FULL;
            end
          end else begin
            if (pc_load) begin
              pend_q  <= 1'b0;
              state_q <= S_DRAIN;
            end else if (ir_en) begin
              pend_q     <= 1'b1;
              pend_inc_q <= increment;
            end else if (increment && !pend_q) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_FULL: begin
          if (pc_load || increment) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_d;
          end
          if (pc_load) begin
            pend_q <= 1'b0;
          end else if (ir_en) begin
            ir_q    <= buf_q;
            pc_q    <= fetch_pc_q;
            valid_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (pc_load) begin
            pend_q <= 1'b0;
          end else if (ir_en) begin
            pend_q     <= 1'b1;
            pend_inc_q <= increment;
          end
          if (imem_ack) begin
            state_q <= S_REQ;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
          addr_q  <= fetch_pc_q;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instruction = ir_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign fetch_stall = pend_q;

  // an outstanding request can never be moved or withdrawn
  a_req_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_req && !imem_ack |=> imem_req && $stable(imem_addr)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable imem model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        increment;
  logic        ir_en;
  logic        pc_load;
  logic [7:0]  pc_load_addr;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        fetch_stall;

  instr_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .increment    (increment),
    .ir_en        (ir_en),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .fetch_stall  (fetch_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [256];

  logic        auto_en = 1'b1;
  logic        rnd     = 1'b0;
  int          lat     = 0;
  logic        ack_a;
  logic        ack_m;
  logic [15:0] rd_a;
  logic [15:0] rd_m;

  assign imem_ack   = auto_en ? ack_a : ack_m;
  assign imem_rdata = auto_en ? rd_a : rd_m;

  initial begin
    int cnt;
    int rlat;
    cnt  = 0;
    rlat = 0;
    ack_a = 1'b0;
    rd_a  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && imem_req) begin
        if (cnt >= (rnd ? rlat : lat)) begin
          ack_a = 1'b1;
          rd_a  = mem[imem_addr];
          cnt   = 0;
          rlat  = $urandom_range(0, 2);
        end else begin
          ack_a = 1'b0;
          cnt++;
        end
      end else begin
        ack_a = 1'b0;
        cnt   = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input logic [7:0] a, input string tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (imem_req && imem_addr == a) hit = 1'b1;
      else cyc(1);
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = {8'(i) ^ 8'h5C, 8'(i)};
    mem[0] = 16'h2A80;
    rst_n = 1'b0;
    increment = 1'b0;
    ir_en = 1'b0;
    pc_load = 1'b0;
    pc_load_addr = '0;
    ack_m = 1'b0;
    rd_m = '0;

    // reset values
    cyc(2);
    check("rst_ir", 32'(instruction), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_stall", 32'(fetch_stall), 32'd0);
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_addr", 32'(imem_addr), 32'h0);
    rst_n = 1'b1;

    // 1: zero-latency ack fills buffer, ir_en+increment loads IR
    cyc(1);
    check("t1_req", 32'(imem_req), 32'd1);
    check("t1_addr", 32'(imem_addr), 32'h0);
    cyc(1);
    check("t1_full_req", 32'(imem_req), 32'd0);
    ir_en = 1'b1;
    increment = 1'b1;
    lat = 3;
    cyc(1);
    ir_en = 1'b0;
    increment = 1'b0;
    check("t1_ir", 32'(instruction), 32'h2A80);
    check("t1_pc", 32'(pc), 32'h0);
    check("t1_valid", 32'(instr_valid), 32'd1);
    check("t1_naddr", 32'(imem_addr), 32'h1);
    check("t1_nreq", 32'(imem_req), 32'd1);

    // 2: ack latency 3, ir_en+increment in first request cycle
    ir_en = 1'b1;
    increment = 1'b1;
    cyc(1);
    ir_en = 1'b0;
    increment = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_stall", 32'(fetch_stall), 32'd1);
      check("t2_ir_hold", 32'(instruction), 32'h2A80);
      cyc(1);
    end
    check("t2_stall_end", 32'(fetch_stall), 32'd0);
    check("t2_ir", 32'(instruction), 32'h5D01);
    check("t2_pc", 32'(pc), 32'h1);
    cyc(1);
    check("t2_nreq", 32'(imem_req), 32'd1);
    check("t2_naddr", 32'(imem_addr), 32'h2);

    // 3: redirect to 0x40 while fetch of 5 is outstanding
    pc_load = 1'b1;
    pc_load_addr = 8'h05;
    cyc(1);
    pc_load = 1'b0;
    wait_req(8'h05, "t3_req5");
    pc_load = 1'b1;
    pc_load_addr = 8'h40;
    cyc(1);
    pc_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_req", 32'(imem_req), 32'd1);
      check("t3_hold_addr", 32'(imem_addr), 32'h05);
      check("t3_ir", 32'(instruction), 32'h5D01);
      cyc(1);
    end
    check("t3_idle", 32'(imem_req), 32'd0);
    cyc(1);
    check("t3_nreq", 32'(imem_req), 32'd1);
    check("t3_naddr", 32'(imem_addr), 32'h40);
    check("t3_ir_end", 32'(instruction), 32'h5D01);

    // 4: PC wrap from 0xFF
    lat = 0;
    pc_load = 1'b1;
    pc_load_addr = 8'hFF;
    cyc(1);
    pc_load = 1'b0;
    wait_req(8'hFF, "t4_reqff");
    cyc(1);
    check("t4_full", 32'(imem_req), 32'd0);
    ir_en = 1'b1;
    increment = 1'b1;
    lat = 5;
    cyc(1);
    ir_en = 1'b0;
    increment = 1'b0;
    check("t4_pc", 32'(pc), 32'hFF);
    check("t4_ir", 32'(instruction), 32'hA3FF);
    check("t4_naddr", 32'(imem_addr), 32'h00);
    check("t4_nreq", 32'(imem_req), 32'd1);

    // 5: reset while request outstanding, stale ack during reset
    rst_n = 1'b0;
    auto_en = 1'b0;
    ack_m = 1'b1;
    rd_m = 16'hDEAD;
    #1;
    check("t5_valid", 32'(instr_valid), 32'd0);
    check("t5_ir", 32'(instruction), 32'h0);
    check("t5_pc", 32'(pc), 32'h0);
    check("t5_addr", 32'(imem_addr), 32'h0);
    cyc(2);
    check("t5_ir_stale", 32'(instruction), 32'h0);
    rst_n = 1'b1;
    ack_m = 1'b0;
    auto_en = 1'b1;
    cyc(1);
    check("t5_post_ir", 32'(instruction), 32'h0);
    check("t5_post_valid", 32'(instr_valid), 32'd0);
    check("t5_post_req", 32'(imem_req), 32'd1);
    check("t5_post_addr", 32'(imem_addr), 32'h0);

    // 6: control-unit loop with random ack latency
    rst_n = 1'b0;
    rnd = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    for (int k = 0; k < 200; k++) begin
      int w;
      ir_en = 1'b1;
      increment = 1'b1;
      cyc(1);
      ir_en = 1'b0;
      increment = 1'b0;
      w = 0;
      while (fetch_stall && w < 10) begin
        cyc(1);
        w++;
      end
      check("t6_stall", 32'(fetch_stall), 32'd0);
      check("t6_ir", 32'(instruction), 32'(mem[k]));
      check("t6_pc", 32'(pc), 32'(k[7:0]));
      cyc(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
